// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for the hsync/vsync/bright stream of the VGA timer.
// Rebuilds pixel coordinates from the sync/blank signals, measures line and frame geometry,
// and reports sticky timing errors plus a lock indication.
//
// Ports:
//   clk          system clock
//   clear        asynchronous active-low reset
//   pix_en       pixel strobe; inputs are sampled only on edges with pix_en=1
//   hsync/vsync  sync inputs, asserted level SYNC_POL
//   bright       visible-area indicator
//   err_clr      synchronous clear of h_err/v_err (independent of pix_en)
//   px_x/px_y    column/row of the last visible sample, px_valid pulses with each one
//   line_len     samples in the last complete line
//   frame_lines  lines in the last complete frame
//   h_err/v_err  sticky horizontal/vertical timing errors
//   locked       LOCK_FRAMES consecutive good frames seen
//   frame_done   one-clk pulse at each measured frame boundary
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter bit          SYNC_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       bright,
  input  logic       err_clr,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       px_valid,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       h_err,
  output logic       v_err,
  output logic       locked,
  output logic       frame_done
);

  localparam logic [9:0]  CntMax   = '1;
  localparam logic [10:0] HTotalW  = 11'(H_TOTAL);
  localparam logic [9:0]  HSyncW   = 10'(H_SYNC);
  localparam logic [9:0]  HActiveW = 10'(H_ACTIVE);
  localparam logic [9:0]  VTotalW  = 10'(V_TOTAL);
  localparam logic [9:0]  VSyncW   = 10'(V_SYNC);
  localparam logic [9:0]  VActiveW = 10'(V_ACTIVE);
  localparam logic [3:0]  LockW    = 4'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CntMax) ? v : v + 10'd1;
  endfunction

  logic       hs_prev_q, vs_prev_q, h_seen_q, v_seen_q, ferr_q;
  logic [9:0] hcnt_q, hwid_q, xcnt_q, vcnt_q, ycnt_q, vwid_q;
  logic [3:0] good_q, good_d;
  logic [9:0] px_x_q, px_y_q, line_len_q, frame_lines_q;
  logic       px_valid_q, h_err_q, v_err_q, locked_q, frame_done_q;

  logic        hs_act, vs_act, h_start, h_end, v_start, v_end, h_close, v_close;
  logic [10:0] line_meas;
  logic        h_set, v_set, any_set;
  logic [9:0]  hcnt_d, hwid_d, xcnt_base, xcnt_d, vcnt_inc, ycnt_inc, vcnt_d, ycnt_d, vwid_d;
  logic        h_err_d, v_err_d;

  always_comb begin
    hs_act  = (hsync == SYNC_POL);
    vs_act  = (vsync == SYNC_POL);
    h_start = hs_act & (hs_prev_q != SYNC_POL);
    h_end   = ~hs_act & (hs_prev_q == SYNC_POL);
    v_start = vs_act & (vs_prev_q != SYNC_POL);
    v_end   = ~vs_act & (vs_prev_q == SYNC_POL);
    // Only lines/frames bounded by two sync starts are measured.
    h_close = h_start & h_seen_q;
    v_close = v_start & v_seen_q;

    hcnt_d    = h_start ? 10'd0 : sat_inc(hcnt_q);
    line_meas = {1'b0, hcnt_q} + 11'd1;
    hwid_d    = h_start ? 10'd1 : (hs_act ? sat_inc(hwid_q) : hwid_q);

    xcnt_base = h_start ? 10'd0 : xcnt_q;
    xcnt_d    = bright ? sat_inc(xcnt_base) : xcnt_base;

    // The closing line is counted into the ending frame before any v_start zeroing.
    vcnt_inc = h_start ? sat_inc(vcnt_q) : vcnt_q;
    ycnt_inc = (h_start && xcnt_q != 10'd0) ? sat_inc(ycnt_q) : ycnt_q;
    vcnt_d   = v_start ? 10'd0 : vcnt_inc;
    ycnt_d   = v_start ? 10'd0 : ycnt_inc;
    if (v_start) begin
      vwid_d = h_start ? 10'd1 : 10'd0;
    end else begin
      vwid_d = (vs_act && h_start) ? sat_inc(vwid_q) : vwid_q;
    end

    h_set = 1'b0;
    if (h_close && ((line_meas != HTotalW) || (hcnt_q == CntMax))) h_set = 1'b1;
    if (h_close && (xcnt_q != 10'd0) && (xcnt_q != HActiveW)) h_set = 1'b1;
    if (h_end && h_seen_q && (hwid_q != HSyncW)) h_set = 1'b1;
    h_set = h_set & pix_en;

    v_set = 1'b0;
    if (v_close && ((vcnt_inc != VTotalW) || (ycnt_inc != VActiveW))) v_set = 1'b1;
    if (v_end && v_seen_q && (vwid_q != VSyncW)) v_set = 1'b1;
    v_set = v_set & pix_en;

    any_set = h_set | v_set;

    good_d = good_q;
    if (v_close) begin
      if (!ferr_q && !any_set && (vcnt_inc == VTotalW)) begin
        good_d = (good_q == 4'hf) ? good_q : good_q + 4'd1;
      end else begin
        good_d = 4'd0;
      end
    end

    // A set event in the same cycle as err_clr wins.
    h_err_d = h_set | (h_err_q & ~err_clr);
    v_err_d = v_set | (v_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      hs_prev_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      ferr_q        <= 1'b0;
      hcnt_q        <= '0;
      hwid_q        <= '0;
      xcnt_q        <= '0;
      vcnt_q        <= '0;
      ycnt_q        <= '0;
      vwid_q        <= '0;
      good_q        <= '0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      px_valid_q    <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      px_valid_q   <= pix_en & bright;
      frame_done_q <= pix_en & v_close;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
      if (pix_en) begin
        hs_prev_q <= hsync;
        vs_prev_q <= vsync;
        h_seen_q  <= h_seen_q | h_start;
        v_seen_q  <= v_seen_q | v_start;
        ferr_q    <= v_start ? 1'b0 : (ferr_q | any_set);
        hcnt_q    <= hcnt_d;
        hwid_q    <= hwid_d;
        xcnt_q    <= xcnt_d;
        vcnt_q    <= vcnt_d;
        ycnt_q    <= ycnt_d;
        vwid_q    <= vwid_d;
        good_q    <= good_d;
        locked_q  <= (good_d >= LockW);
        if (bright) begin
          px_x_q <= xcnt_base;
          px_y_q <= ycnt_d;
        end
        if (h_close) line_len_q <= line_meas[9:0];
        if (v_close) frame_lines_q <= vcnt_inc;
      end
    end
  end

  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_valid    = px_valid_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor with a scaled-down raster (40x14 samples, 24x8 visible).
module tb_vga_timing_monitor;

  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int HA  = 24;
  localparam int HA0 = 10;
  localparam int VT  = 14;
  localparam int VS  = 2;
  localparam int VA  = 8;
  localparam int VS0 = 10;
  localparam int LF  = 2;

  logic       clk = 1'b0;
  logic       clear, pix_en, hsync, vsync, bright, err_clr;
  logic [9:0] px_x, px_y, line_len, frame_lines;
  logic       px_valid, h_err, v_err, locked, frame_done;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_SYNC(VS), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .clear(clear), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .bright(bright),
    .err_clr(err_clr), .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .line_len(line_len),
    .frame_lines(frame_lines), .h_err(h_err), .v_err(v_err), .locked(locked),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run = 0;
  bit half = 0;
  bit rst_armed = 0;
  bit post_rst = 0;
  int rst_vp = 0;
  int rst_hp = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamps of sync starts and a per-frame list of visible-sample counts.
  int n, last_h, bc, htot, vs_mark, good;
  bit m_hs_prev, m_vs_prev, m_h_seen, m_v_seen, ferr;
  int frame_q[$];
  int m_px_x, m_px_y, m_line_len, m_frame_lines;
  bit m_px_valid, m_h_err, m_v_err, m_locked, m_frame_done;

  function automatic int visible_rows();
    int c = 0;
    foreach (frame_q[i]) if (frame_q[i] != 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    n = 0; last_h = 0; bc = 0; htot = 0; vs_mark = 0; good = 0;
    m_hs_prev = 0; m_vs_prev = 0; m_h_seen = 0; m_v_seen = 0; ferr = 0;
    frame_q.delete();
    m_px_x = 0; m_px_y = 0; m_line_len = 0; m_frame_lines = 0;
    m_px_valid = 0; m_h_err = 0; m_v_err = 0; m_locked = 0; m_frame_done = 0;
  endtask

  task automatic model_step();
    bit hs_a, vs_a, hst, hen, vst, ven, hset, vset;
    int h_before;
    hset = 0; vset = 0;
    m_px_valid = 0; m_frame_done = 0;
    if (pix_en) begin
      hs_a = (hsync == 1'b0);
      vs_a = (vsync == 1'b0);
      hst = hs_a && !m_hs_prev;
      hen = !hs_a && m_hs_prev;
      vst = vs_a && !m_vs_prev;
      ven = !vs_a && m_vs_prev;
      h_before = htot;
      if (hst) begin
        if (m_h_seen) begin
          m_line_len = (n - last_h) & 1023;
          if (n - last_h != HT) hset = 1;
          if (bc != 0 && bc != HA) hset = 1;
        end
        frame_q.push_back(bc);
        m_h_seen = 1; last_h = n; bc = 0; htot++;
      end
      if (hen && m_h_seen && (n - last_h) != HS) hset = 1;
      if (vst) begin
        if (m_v_seen) begin
          m_frame_lines = frame_q.size();
          if (frame_q.size() != VT || visible_rows() != VA) vset = 1;
          if (!ferr && !hset && !vset && frame_q.size() == VT) good = (good < 15) ? good + 1 : 15;
          else good = 0;
          m_frame_done = 1;
        end
        frame_q.delete();
        m_v_seen = 1; vs_mark = h_before; ferr = 0;
      end else begin
        ferr = ferr | hset;
      end
      if (ven && m_v_seen && (h_before - vs_mark) != VS) vset = 1;
      if (!vst) ferr = ferr | vset;
      if (bright) begin
        m_px_valid = 1; m_px_x = bc; m_px_y = visible_rows(); bc++;
      end
      m_locked = (good >= LF);
      n++;
      m_hs_prev = hs_a; m_vs_prev = vs_a;
    end
    m_h_err = hset | (m_h_err & !err_clr);
    m_v_err = vset | (m_v_err & !err_clr);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge clear);
      if (!clear) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("px_valid", int'(px_valid), int'(m_px_valid));
        chk("px_x", int'(px_x), m_px_x);
        chk("px_y", int'(px_y), m_px_y);
        chk("line_len", int'(line_len), m_line_len);
        chk("frame_lines", int'(frame_lines), m_frame_lines);
        chk("h_err", int'(h_err), int'(m_h_err));
        chk("v_err", int'(v_err), int'(m_v_err));
        chk("locked", int'(locked), int'(m_locked));
        chk("frame_done", int'(frame_done), int'(m_frame_done));
      end
    end
  end

  // Pixels seen between consecutive frame_done pulses.
  int pcount = 0;
  int last_frame_px = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (px_valid) pcount++;
      if (frame_done) begin
        last_frame_px = pcount;
        pcount = 0;
      end
    end
  end

  task automatic sample(input logic hs, input logic vs, input logic br, input logic ec);
    hsync = hs; vsync = vs; bright = br; err_clr = ec; pix_en = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    if (half) begin
      pix_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic async_reset(input bit check_zero);
    pix_en = 1'b0;
    #2 clear = 1'b0;
    #1;
    if (check_zero) begin
      chk("outputs_zero_in_reset",
          ({px_x, px_y, px_valid, line_len, frame_lines, h_err, v_err, locked, frame_done} == '0)
          ? 0 : 1, 0);
    end
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
  endtask

  task automatic idle_clr();
    pix_en = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  // nl < VT drops trailing back-porch lines; bad_vp gets an hsync of bad_w samples.
  task automatic send_frame(input int nl, input int bad_vp, input int bad_w,
                            input int ec_vp, input int ec_hp);
    for (int vp = 0; vp < VT; vp++) begin
      if (vp >= nl) continue;
      for (int hp = 0; hp < HT; hp++) begin
        int   w;
        logic hs, vs, br, ec;
        w  = (vp == bad_vp) ? bad_w : HS;
        hs = (hp < w) ? 1'b0 : 1'b1;
        vs = (vp >= VS0 && vp < VS0 + VS) ? 1'b0 : 1'b1;
        br = (vp < VA && hp >= HA0 && hp < HA0 + HA);
        ec = (vp == ec_vp && hp == ec_hp);
        if (rst_armed && vp == rst_vp && hp == rst_hp) begin
          rst_armed = 0;
          async_reset(1);
          post_rst = 1;
        end
        sample(hs, vs, br, ec);
        if (post_rst && vp == rst_vp + 1 && hp == 0) begin
          post_rst = 0;
          chk("line_len_after_first_hstart", int'(line_len), 0);
        end
      end
    end
  endtask

  initial begin
    clear = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; bright = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_line_len", int'(line_len), 0);
    chk("reset_locked", int'(locked), 0);
    clear = 1'b1;
    run = 1;

    // Nominal stream, four frames.
    repeat (4) send_frame(VT, -1, 0, -1, -1);
    chk("nom_line_len", int'(line_len), 40);
    chk("nom_frame_lines", int'(frame_lines), 14);
    chk("nom_h_err", int'(h_err), 0);
    chk("nom_v_err", int'(v_err), 0);
    chk("nom_locked", int'(locked), 1);
    chk("nom_px_per_frame", last_frame_px, 192);
    chk("nom_last_px_x", int'(px_x), 23);
    chk("nom_last_px_y", int'(px_y), 7);

    // Short hsync pulse on one line.
    send_frame(VT, 3, HS - 1, -1, -1);
    chk("hw_h_err", int'(h_err), 1);
    chk("hw_unlocked", int'(locked), 0);
    idle_clr();
    chk("err_clr_h_err", int'(h_err), 0);
    send_frame(VT, -1, 0, -1, -1);
    chk("relock_1_frame", int'(locked), 0);
    send_frame(VT, -1, 0, -1, -1);
    chk("relock_2_frames", int'(locked), 1);

    // Frame one line short; it is measured at the following v_start.
    send_frame(VT - 1, -1, 0, -1, -1);
    send_frame(VT, -1, 0, -1, -1);
    chk("short_frame_lines", int'(frame_lines), 13);
    chk("short_v_err", int'(v_err), 1);
    chk("short_unlocked", int'(locked), 0);
    idle_clr();
    chk("err_clr_v_err", int'(v_err), 0);

    // Reset mid-line in the second frame.
    send_frame(VT, -1, 0, -1, -1);
    rst_vp = 4; rst_hp = 15; rst_armed = 1;
    send_frame(VT, -1, 0, -1, -1);
    chk("post_reset_line_len", int'(line_len), 40);
    chk("post_reset_not_locked", int'(locked), 0);
    send_frame(VT, -1, 0, -1, -1);
    chk("post_reset_2_vstarts", int'(locked), 0);
    send_frame(VT, -1, 0, -1, -1);
    chk("post_reset_3_vstarts", int'(locked), 1);

    // Half-rate pixel strobe.
    async_reset(0);
    half = 1;
    repeat (4) send_frame(VT, -1, 0, -1, -1);
    half = 0;
    chk("half_line_len", int'(line_len), 40);
    chk("half_frame_lines", int'(frame_lines), 14);
    chk("half_px_per_frame", last_frame_px, 192);
    chk("half_locked", int'(locked), 1);

    // err_clr on the very sample that ends a short hsync pulse.
    send_frame(VT, 3, HS - 1, 3, HS - 1);
    chk("clr_vs_set_h_err", int'(h_err), 1);

    run = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side checker for the VGA timing stream produced by the team's VGA timer (hsync, vsync, bright).
- Rebuilds pixel coordinates from the sync/blank signals alone and measures line and frame geometry against nominal 640x480.
- Reports sticky timing errors and a lock indication.
- Sits beside the timer in the VGA subsystem; used in simulation and on-chip as a timing self-check.

Parameters:
H_TOTAL, 800, samples per line
H_SYNC, 96, hsync pulse width in samples
H_ACTIVE, 640, bright samples per visible line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync pulse width in lines
V_ACTIVE, 480, visible lines per frame
LOCK_FRAMES, 2, consecutive good frames required for lock
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
clear  in  1  reset, asynchronous, active-low (0 = reset)
pix_en  in  1  pixel strobe; inputs are sampled only on clk edges with pix_en=1
hsync  in  1  horizontal sync from timer
vsync  in  1  vertical sync from timer
bright  in  1  visible-area indicator from timer
err_clr  in  1  synchronous clear of h_err/v_err
px_x  out  10  column of last visible sample
px_y  out  10  row of last visible sample
px_valid  out  1  px_x/px_y valid this cycle
line_len  out  10  measured samples in last complete line
frame_lines  out  10  measured lines in last complete frame
h_err  out  1  sticky horizontal timing error
v_err  out  1  sticky vertical timing error
locked  out  1  timing lock
frame_done  out  1  one-clk pulse at each frame boundary

Behaviour:
- Reset (clear=0, asynchronous): every output is 0. All counters are 0. Previous-sync registers are set to the inactive level (~SYNC_POL). The h_seen and v_seen flags are 0.
- Sampling: all state advances only on pix_en=1 edges, except px_valid and frame_done, which are 0 on any edge with pix_en=0.
- Edges:
  - h_start = hsync goes inactive→asserted between consecutive samples.
  - h_end = asserted→inactive.
  - v_start and v_end are defined the same way for vsync.
- Horizontal counting:
  - hcnt is 0 on the h_start sample and +1 on each later sample. It saturates at 1023.
  - At h_start with h_seen=1: line_len <= hcnt+1.
  - h_err sets if hcnt+1 != H_TOTAL or hcnt saturated.
  - The first h_start after reset only sets h_seen.
- Hsync width: count samples while hsync is asserted. At h_end, width != H_SYNC sets h_err.
- Active count:
  - xcnt counts bright samples in the line and is zeroed at h_start.
  - At h_start, a closing line with xcnt not in {0, H_ACTIVE} sets h_err.
- Pixel output: on a sample with bright=1, the next clk has px_valid=1, px_x=xcnt (pre-increment) and px_y=ycnt. Latency is 1 clk.
- Vertical:
  - vcnt counts h_start events since the last v_start.
  - ycnt increments at h_start when the closing line had xcnt>0.
  - At v_start with v_seen=1: frame_lines <= vcnt and frame_done pulses for 1 clk. v_err sets if vcnt != V_TOTAL or ycnt != V_ACTIVE.
  - After that check, vcnt and ycnt are zeroed. The first v_start after reset only sets v_seen.
- Vsync width: count h_start events while vsync is asserted. At v_end, count != V_SYNC sets v_err.
- Simultaneous h_start and v_start on one sample: the line is closed first and counted into the ending frame, then the frame is closed. The new line is line 0 of the new frame.
- Lock:
  - good counter (saturating), evaluated at each counted v_start.
  - If no h_err/v_err set event occurred during the frame and vcnt == V_TOTAL, good+1; otherwise good = 0.
  - locked = (good >= LOCK_FRAMES), registered.
- err_clr: clears h_err/v_err on the next pix_en-independent clk edge. A set event in the same cycle wins, so the flag stays 1.
- Reset mid-frame: immediate return to reset values. Partial lines and frames after release are never measured, because of the h_seen/v_seen gating.

Test Plan:
- Release clear, nominal timer stream, pix_en=1, 4 frames:
  - line_len=800, frame_lines=525, h_err=v_err=0.
  - 307200 px_valid pulses per frame; last px_x=639, px_y=479.
  - locked=1 one clk after the 3rd v_start.
- One line with a 95-sample hsync → h_err=1 one clk after that h_end; locked=0 at next v_start. err_clr → h_err=0; locked=1 after 2 further good frames.
- Frame with 524 lines → frame_lines=524, v_err=1, locked=0 after that v_start.
- clear pulsed low mid-line in frame 2:
  - all outputs 0 asynchronously.
  - no line_len update until the 2nd h_start after release.
  - locked after LOCK_FRAMES+1 v_starts.
- pix_en high every other clk, same stream → identical line_len/frame_lines/px counts; px_valid never high on pix_en=0 cycles.
- err_clr asserted the same cycle as an hsync-width error → h_err remains 1.
